sudoku_board_writer: RTL and testbench

//  Owns the game board array consumed by the board number renderer. Loads a puzzle

---
 rtl/sudoku_board_writer_pkg.sv | 41 ++++
 rtl/sudoku_board_writer_if.sv | 16 +
 rtl/sudoku_board_writer_cursor.sv | 33 +++
 rtl/sudoku_board_writer.sv | 176 +++++++++++++++++
 tb/tb_sudoku_board_writer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sudoku_board_writer_pkg.sv
// Shared types and constants for the sudoku board writer: command encoding,
// FSM states and helpers that turn the sub-grid size into a board dimension.
package sudoku_board_writer_pkg;

  localparam int MAX_DIM = 16;
  localparam int CELL_W  = 5;
  localparam int PUZ_AW  = 8;
  localparam int PUZ_DW  = 6;
  localparam int CNT_W   = 9;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_UP       = 3'd1,
    CMD_DOWN     = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_RIGHT    = 3'd4,
    CMD_SET      = 3'd5,
    CMD_CLEAR    = 3'd6,
    CMD_NEW_GAME = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // Sub-grid sizes outside 2..4 fall back to the classic 3 (9x9 board).
  function automatic logic [2:0] legal_size(input logic [2:0] s);
    return (s >= 3'd2 && s <= 3'd4) ? s : 3'd3;
  endfunction

  function automatic logic [4:0] dim_of(input logic [2:0] s);
    case (s)
      3'd2:    return 5'd4;
      3'd4:    return 5'd16;
      default: return 5'd9;
    endcase
  endfunction

endpackage

// File: rtl/sudoku_board_writer_if.sv
// Player command channel from the keyboard decoder into the board writer.
// A command transfers on a clock edge where cmd_valid && cmd_ready; cmd, cmd_digit
// and board_size must be stable while cmd_valid is high; cmd_ready never depends on cmd_*.
interface sudoku_board_writer_if;
  import sudoku_board_writer_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  cmd_t       cmd;
  logic [4:0] cmd_digit;
  logic [2:0] board_size;

  modport master (output cmd_valid, cmd, cmd_digit, board_size, input cmd_ready);
  modport slave  (input cmd_valid, cmd, cmd_digit, board_size, output cmd_ready);

endinterface

// File: rtl/sudoku_board_writer_cursor.sv
// Cursor position register: single-step moves that wrap at both ends of 0..n-1.
module board_cursor
  import sudoku_board_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       home,
  input  logic       move_en,
  input  cmd_t       move,
  input  logic [4:0] n,
  output logic [3:0] row,
  output logic [3:0] col
);

  logic [3:0] last;
  assign last = 4'(n - 5'd1);

  always_ff @(posedge clk) begin
    if (rst || home) begin
      row <= 4'd0;
      col <= 4'd0;
    end else if (move_en) begin
      case (move)
        CMD_UP:    row <= (row == 4'd0) ? last : row - 4'd1;
        CMD_DOWN:  row <= (row == last) ? 4'd0 : row + 4'd1;
        CMD_LEFT:  col <= (col == 4'd0) ? last : col - 4'd1;
        CMD_RIGHT: col <= (col == last) ? 4'd0 : col + 4'd1;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/sudoku_board_writer.sv
// Board owner for the sudoku VGA chain: loads a puzzle from the registered ROM,
// then applies player commands and tracks empty cells to flag a solved board.
module sudoku_board_writer
  import sudoku_board_writer_pkg::*;
#(
  parameter int PUZ_LAT = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  sudoku_board_writer_if.slave                        cmd_if,
  output logic [PUZ_AW-1:0]                           puz_addr,
  input  logic [PUZ_DW-1:0]                           puz_data,
  output logic [MAX_DIM-1:0][MAX_DIM-1:0][CELL_W-1:0] board,
  output logic [3:0]                                  cursor_row,
  output logic [3:0]                                  cursor_col,
  output logic                                        is_game_on,
  output logic                                        solved,
  output state_t                                      state_dbg,
  output logic [CNT_W-1:0]                            empty_cnt_dbg
);

  state_t                     state_q, state_d;
  logic                       ready_q, ready_d;
  logic                       acc, new_game;
  logic [2:0]                 size_q, size_new;
  logic [4:0]                 n_q, n_new;
  logic [CNT_W-1:0]           nn_q, nn_new, empty_cnt;
  logic [9:0]                 ld_cnt;
  logic [3:0]                 ld_row, ld_col, last;
  logic                       issuing, ld_done;
  logic [MAX_DIM-1:0][MAX_DIM-1:0] given_q;
  logic [MAX_DIM-1:0][MAX_DIM-1:0][CELL_W-1:0] board_q;
  logic [PUZ_LAT-1:0]         pend_v;
  logic [3:0]                 pend_r [PUZ_LAT];
  logic [3:0]                 pend_c [PUZ_LAT];
  logic                       wr_v, ld_legal, dig_ok;
  logic [3:0]                 wr_r, wr_c;
  logic [4:0]                 pv, cur_val;
  logic                       cur_given;

  assign size_new = legal_size(cmd_if.board_size);
  assign n_new    = dim_of(size_new);
  assign nn_new   = 9'(n_new) * 9'(n_new);
  assign n_q      = dim_of(size_q);
  assign nn_q     = 9'(n_q) * 9'(n_q);
  assign last     = 4'(n_q - 5'd1);

  assign acc      = cmd_if.cmd_valid && ready_q;
  assign new_game = acc && (cmd_if.cmd == CMD_NEW_GAME);
  assign issuing  = (state_q == ST_LOAD) && (ld_cnt < 10'(nn_q));
  assign ld_done  = (ld_cnt == 10'(nn_q) + 10'(PUZ_LAT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (new_game) state_d = ST_LOAD;
      ST_LOAD: if (ld_done)  state_d = ST_PLAY;
      ST_PLAY: if (new_game) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
    // Registered ready keeps cmd_* off any combinational path to cmd_ready.
    ready_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      solved  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      solved  <= (state_q == ST_PLAY) && (empty_cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      ld_cnt <= '0;
      ld_row <= 4'd0;
      ld_col <= 4'd0;
    end else if (state_q == ST_LOAD) begin
      ld_cnt <= ld_cnt + 10'd1;
      if (issuing && ld_cnt != 10'(nn_q) - 10'd1) begin
        if (ld_col == last) begin
          ld_col <= 4'd0;
          ld_row <= ld_row + 4'd1;
        end else begin
          ld_col <= ld_col + 4'd1;
        end
      end
    end
  end

  // Delay line pairs each ROM word with the cell it was addressed for.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      pend_v <= '0;
    end else begin
      pend_v[0] <= issuing;
      for (int i = 1; i < PUZ_LAT; i++) pend_v[i] <= pend_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pend_r[0] <= ld_row;
    pend_c[0] <= ld_col;
    for (int i = 1; i < PUZ_LAT; i++) begin
      pend_r[i] <= pend_r[i-1];
      pend_c[i] <= pend_c[i-1];
    end
  end

  assign wr_v      = pend_v[PUZ_LAT-1] && (state_q == ST_LOAD);
  assign wr_r      = pend_r[PUZ_LAT-1];
  assign wr_c      = pend_c[PUZ_LAT-1];
  assign pv        = puz_data[4:0];
  assign ld_legal  = (pv != 5'd0) && (pv <= n_q);
  assign dig_ok    = (cmd_if.cmd_digit != 5'd0) && (cmd_if.cmd_digit <= n_q);
  assign cur_val   = board_q[cursor_row][cursor_col];
  assign cur_given = given_q[cursor_row][cursor_col];

  always_ff @(posedge clk) begin
    if (rst) begin
      board_q   <= '0;
      given_q   <= '0;
      empty_cnt <= '0;
      size_q    <= 3'd3;
    end else if (new_game) begin
      board_q   <= '0;
      given_q   <= '0;
      empty_cnt <= nn_new;
      size_q    <= size_new;
    end else if (wr_v) begin
      if (ld_legal) begin
        board_q[wr_r][wr_c] <= pv;
        given_q[wr_r][wr_c] <= puz_data[5];
        empty_cnt           <= empty_cnt - 9'd1;
      end else begin
        board_q[wr_r][wr_c] <= 5'd0;
        given_q[wr_r][wr_c] <= 1'b0;
      end
    end else if (acc && state_q == ST_PLAY) begin
      case (cmd_if.cmd)
        CMD_SET: if (dig_ok && !cur_given) begin
          board_q[cursor_row][cursor_col] <= cmd_if.cmd_digit;
          if (cur_val == 5'd0) empty_cnt <= empty_cnt - 9'd1;
        end
        CMD_CLEAR: if (!cur_given && cur_val != 5'd0) begin
          board_q[cursor_row][cursor_col] <= 5'd0;
          empty_cnt <= empty_cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

  board_cursor u_cursor (
    .clk     (clk),
    .rst     (rst),
    .home    (new_game),
    .move_en (acc && state_q == ST_PLAY),
    .move    (cmd_if.cmd),
    .n       (n_q),
    .row     (cursor_row),
    .col     (cursor_col)
  );

  assign cmd_if.cmd_ready = ready_q;
  assign puz_addr         = {ld_row, ld_col};
  assign board            = board_q;
  assign is_game_on       = (state_q == ST_PLAY);
  assign state_dbg        = state_q;
  assign empty_cnt_dbg    = empty_cnt;

endmodule

// File: tb/tb_sudoku_board_writer.sv
// Directed bench for sudoku_board_writer: reset, puzzle load, cursor wrap,
// given-cell protection, solved flag and reset during a long load.
module tb_sudoku_board_writer;
  import sudoku_board_writer_pkg::*;

  logic                                        clk;
  logic                                        rst;
  logic [PUZ_AW-1:0]                           puz_addr;
  logic [PUZ_DW-1:0]                           puz_data;
  logic [MAX_DIM-1:0][MAX_DIM-1:0][CELL_W-1:0] board;
  logic [3:0]                                  cursor_row, cursor_col;
  logic                                        is_game_on, solved;
  state_t                                      state_dbg;
  logic [CNT_W-1:0]                            empty_cnt_dbg;
  logic [5:0]                                  rom [256];
  int                                          tests, failed, cnt;

  sudoku_board_writer_if cmd_if ();

  sudoku_board_writer #(.PUZ_LAT(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_if        (cmd_if),
    .puz_addr      (puz_addr),
    .puz_data      (puz_data),
    .board         (board),
    .cursor_row    (cursor_row),
    .cursor_col    (cursor_col),
    .is_game_on    (is_game_on),
    .solved        (solved),
    .state_dbg     (state_dbg),
    .empty_cnt_dbg (empty_cnt_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered puzzle ROM, one cycle latency
  always_ff @(posedge clk) puz_data <= rom[puz_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input cmd_t c, input logic [4:0] digit);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd       = c;
    cmd_if.cmd_digit = digit;
    tick();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd       = CMD_NOP;
    cmd_if.cmd_digit = 5'd0;
  endtask

  // Issue NEW_GAME and count LOAD cycles until PLAY (bounded).
  task automatic new_game(input logic [2:0] size, input int exp_len, input string tag);
    cmd_if.board_size = size;
    send(CMD_NEW_GAME, 5'd0);
    cnt = 0;
    while (!is_game_on && cnt < 400) begin
      tick();
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_len));
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd        = CMD_NOP;
    cmd_if.cmd_digit  = 5'd0;
    cmd_if.board_size = 3'd2;
    for (int i = 0; i < 256; i++) rom[i] = 6'd0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state and IDLE
    check("ready_after_rst", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    check("ready_idle", 32'(cmd_if.cmd_ready), 32'd1);
    repeat (10) tick();
    check("idle_board_zero", 32'(|board), 32'd0);
    check("idle_game_on", 32'(is_game_on), 32'd0);
    check("idle_solved", 32'(solved), 32'd0);
    check("idle_state", 32'(state_dbg), 32'(ST_IDLE));
    check("idle_empty", 32'(empty_cnt_dbg), 32'd0);
    check("idle_addr", 32'(puz_addr), 32'd0);
    send(CMD_RIGHT, 5'd0);
    check("idle_drop_col", 32'(cursor_col), 32'd0);
    check("idle_drop_state", 32'(state_dbg), 32'(ST_IDLE));

    // 4x4, empty ROM
    new_game(3'd2, 17, "load_len_4x4");
    check("play_state", 32'(state_dbg), 32'(ST_PLAY));
    check("play_empty16", 32'(empty_cnt_dbg), 32'd16);
    check("play_cursor", 32'({cursor_row, cursor_col}), 32'h00);
    check("play_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("play_solved0", 32'(solved), 32'd0);

    // wrap-around moves
    send(CMD_LEFT, 5'd0);
    check("left_wrap", 32'(cursor_col), 32'd3);
    send(CMD_UP, 5'd0);
    check("up_wrap", 32'(cursor_row), 32'd3);
    send(CMD_RIGHT, 5'd0);
    check("right_wrap", 32'(cursor_col), 32'd0);

    // given cell (0,0)=3, out-of-range value 7 at (1,1) loads as empty
    rom[8'h00] = 6'h23;
    rom[8'h11] = 6'h27;
    new_game(3'd2, 17, "load_len_given");
    check("given_empty15", 32'(empty_cnt_dbg), 32'd15);
    check("given_val", 32'(board[0][0]), 32'd3);
    check("illegal_rom_val", 32'(board[1][1]), 32'd0);
    send(CMD_SET, 5'd1);
    check("set_on_given", 32'(board[0][0]), 32'd3);
    send(CMD_CLEAR, 5'd0);
    check("clear_on_given", 32'(board[0][0]), 32'd3);
    check("clear_given_cnt", 32'(empty_cnt_dbg), 32'd15);
    send(CMD_RIGHT, 5'd0);
    send(CMD_SET, 5'd5);
    check("set_digit_too_big", 32'(board[0][1]), 32'd0);
    check("set_too_big_cnt", 32'(empty_cnt_dbg), 32'd15);
    send(CMD_SET, 5'd4);
    check("set_legal", 32'(board[0][1]), 32'd4);
    check("set_legal_cnt", 32'(empty_cnt_dbg), 32'd14);

    // 15 cells filled by ROM, (2,3) left empty
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        rom[r*16+c] = {((c % 2) == 0) ? 1'b1 : 1'b0, 5'(((r + c) % 4) + 1)};
    rom[8'h23] = 6'h00;
    new_game(3'd2, 17, "load_len_fill");
    check("fill_empty1", 32'(empty_cnt_dbg), 32'd1);
    check("fill_cell_1_2", 32'(board[1][2]), 32'd4);
    check("fill_cell_3_3", 32'(board[3][3]), 32'd3);
    send(CMD_DOWN, 5'd0);
    send(CMD_DOWN, 5'd0);
    send(CMD_LEFT, 5'd0);
    check("fill_cursor", 32'({cursor_row, cursor_col}), 32'h23);
    send(CMD_SET, 5'd2);
    check("last_set_val", 32'(board[2][3]), 32'd2);
    check("last_set_cnt", 32'(empty_cnt_dbg), 32'd0);
    check("solved_not_yet", 32'(solved), 32'd0);
    tick();
    check("solved_high", 32'(solved), 32'd1);
    send(CMD_CLEAR, 5'd0);
    check("clear_val", 32'(board[2][3]), 32'd0);
    check("clear_cnt", 32'(empty_cnt_dbg), 32'd1);
    tick();
    check("solved_low", 32'(solved), 32'd0);

    // 16x16 load interrupted by reset at LOAD cycle 100
    cmd_if.board_size = 3'd4;
    send(CMD_NEW_GAME, 5'd0);
    repeat (100) tick();
    check("mid_load_state", 32'(state_dbg), 32'(ST_LOAD));
    check("mid_load_addr", 32'(puz_addr), 32'h64);
    check("mid_load_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("mid_load_game_on", 32'(is_game_on), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_board_zero", 32'(|board), 32'd0);
    check("abort_game_on", 32'(is_game_on), 32'd0);
    check("abort_empty", 32'(empty_cnt_dbg), 32'd0);
    check("abort_addr", 32'(puz_addr), 32'd0);
    check("abort_ready", 32'(cmd_if.cmd_ready), 32'd0);

    // out-of-range board_size falls back to 9x9
    tick();
    for (int i = 0; i < 256; i++) rom[i] = 6'd0;
    new_game(3'd7, 82, "load_len_9x9");
    check("size7_empty81", 32'(empty_cnt_dbg), 32'd81);
    send(CMD_LEFT, 5'd0);
    check("size7_wrap", 32'(cursor_col), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
